// File: rtl/lbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lbus_pkg
//  Description : Shared local-bus definitions: initiator FSM encoding and
//                default handshake timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
package lbus_pkg;

    localparam int c_lbus_timeout_dflt = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_READ     = 3'd2,
        ST_READ_END = 3'd3,
        ST_RESP     = 3'd4
    } lbus_state_e;

    // Counter must be able to hold the value TIMEOUT itself.
    function automatic int lbus_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lbus_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : lbus_master_if
//  Description : Command/response channel plus local-bus initiator signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lbus_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_wstrb;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              wen;
    logic [STRB_W-1:0] wstrb;
    logic              wready;
    logic [ADDR_W-1:0] raddr;
    logic              ren;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output waddr, wdata, wen, wstrb, raddr, ren,
        input  wready, rdata, rvalid
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  waddr, wdata, wen, wstrb, raddr, ren,
        output wready, rdata, rvalid
    );

endinterface
`default_nettype wire

// File: rtl/lbus_master.sv
`default_nettype none
// ============================================================================
//  Module      : lbus_master
//  Description : Single-outstanding local-bus initiator with wready/rvalid
//                timeout and held response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module lbus_master
    import lbus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int STRB_W  = DATA_W / 8,
    parameter int TIMEOUT = c_lbus_timeout_dflt
) (
    input  wire            clk,
    input  wire            rst,
    lbus_master_if.master  bus
);

    localparam int c_CNT_W = lbus_cnt_width(TIMEOUT);

    generate
        if (TIMEOUT < 2) begin : g_bad_timeout
            $error("lbus_master: TIMEOUT must be at least 2");
        end
    endgenerate

    lbus_state_e        r_state;
    lbus_state_e        w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [STRB_W-1:0]  r_wstrb;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic [DATA_W-1:0]  w_rsp_rdata_nxt;
    logic               r_rsp_err;
    logic               w_rsp_err_nxt;
    logic               w_cmd_ready;
    logic               w_accept;
    logic               w_cnt_last;

    // Held low while rst is high so no command can slip in during reset.
    assign w_cmd_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept    = bus.cmd_valid && w_cmd_ready;
    // Last waiting cycle: one more increment would reach TIMEOUT.
    assign w_cnt_last  = (r_cnt == c_CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = bus.cmd_we ? ST_WRITE : ST_READ;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WRITE: begin
                if (bus.wready) begin
                    w_state_nxt     = ST_RESP;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = 1'b0;
                end else if (w_cnt_last) begin
                    w_state_nxt     = ST_RESP;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            ST_READ: begin
                if (bus.rvalid) begin
                    w_state_nxt     = ST_READ_END;
                    w_rsp_rdata_nxt = bus.rdata;
                    w_rsp_err_nxt   = 1'b0;
                end else if (w_cnt_last) begin
                    w_state_nxt     = ST_READ_END;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            // One ren-low cycle so the responder can retire rvalid.
            ST_READ_END: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            if (w_accept) begin
                r_addr  <= bus.cmd_addr;
                r_wdata <= bus.cmd_wdata;
                r_wstrb <= bus.cmd_wstrb;
            end
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    assign bus.wen       = (r_state == ST_WRITE);
    assign bus.ren       = (r_state == ST_READ);
    assign bus.waddr     = r_addr;
    assign bus.raddr     = r_addr;
    assign bus.wdata     = r_wdata;
    assign bus.wstrb     = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_lbus_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lbus_master
//  Description : Scoreboard bench for lbus_master with a programmable responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lbus_master;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lbus_master_if #(.ADDR_W(32), .DATA_W(32), .STRB_W(4)) bus ();

    lbus_master #(
        .ADDR_W (32),
        .DATA_W (32),
        .STRB_W (4),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    exp_t        sb[$];

    // Responder controls: -2 = always ready, -1 = never, N = ready on (N+1)th strobe cycle
    int          w_wait = -2;
    int          r_wait = 0;
    logic        stray  = 1'b0;
    logic [31:0] rd_val = '0;

    int          wen_cyc = 0;
    int          ren_cyc = 0;
    logic [31:0] cap_waddr = '0;
    logic [31:0] cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;
    logic [31:0] cap_raddr = '0;
    logic        prev_wen = 1'b0;
    logic        prev_ren = 1'b0;
    logic        excl_bad = 1'b0;
    logic        unstable = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Responder: decides wready/rvalid for the current cycle just after each edge.
    initial begin
        int wcnt;
        int rcnt;
        wcnt = 0;
        rcnt = 0;
        bus.wready = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        forever begin
            tick();
            bus.rdata  = rd_val;
            bus.wready = (w_wait == -2) || stray || (bus.wen && (wcnt == w_wait));
            bus.rvalid = stray || (bus.ren && (rcnt == r_wait));
            wcnt = bus.wen ? wcnt + 1 : 0;
            rcnt = bus.ren ? rcnt + 1 : 0;
        end
    end

    // Bus observer: strobe lengths, captured values, stability, exclusivity.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.wen && bus.ren) excl_bad = 1'b1;
            if (bus.wen) begin
                if (prev_wen && ({cap_waddr, cap_wdata, cap_wstrb} !== {bus.waddr, bus.wdata, bus.wstrb}))
                    unstable = 1'b1;
                wen_cyc   = prev_wen ? wen_cyc + 1 : 1;
                cap_waddr = bus.waddr;
                cap_wdata = bus.wdata;
                cap_wstrb = bus.wstrb;
            end
            if (bus.ren) begin
                if (prev_ren && (cap_raddr !== bus.raddr)) unstable = 1'b1;
                ren_cyc   = prev_ren ? ren_cyc + 1 : 1;
                cap_raddr = bus.raddr;
            end
            prev_wen = bus.wen;
            prev_ren = bus.ren;
        end
    end

    // Response monitor: pops the scoreboard on every response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk({e.tag, "_rdata"}, bus.rsp_rdata, e.rdata);
                    chk({e.tag, "_err"}, bus.rsp_err, e.err);
                end
            end
        end
    end

    // Issue one command from just after an edge; returns once rsp_valid is seen.
    task automatic do_cmd(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_strobe, input string tag,
                          output int wait_cyc);
        int t;
        int lat;
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = data;
        bus.cmd_wstrb = strb;
        #1;
        t = 0;
        while (!bus.cmd_ready && t < 50) begin
            tick();
            t++;
        end
        wait_cyc = t;
        if (!bus.cmd_ready) begin
            chk({tag, "_accept_timeout"}, 0, 1);
            bus.cmd_valid = 1'b0;
            return;
        end
        sb.push_back('{rdata: exp_rdata, err: exp_err, tag: tag});
        tick();
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        if (we) begin
            chk({tag, "_wen_cycles"}, wen_cyc, exp_strobe);
            chk({tag, "_waddr"}, cap_waddr, addr);
            chk({tag, "_wdata"}, cap_wdata, data);
            chk({tag, "_wstrb"}, cap_wstrb, strb);
        end else begin
            chk({tag, "_ren_cycles"}, ren_cyc, exp_strobe);
            chk({tag, "_raddr"}, cap_raddr, addr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_wstrb = '0;
        bus.rsp_ready = 1'b1;

        // Reset values
        repeat (3) tick();
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata_err", {bus.rsp_rdata, bus.rsp_err}, 0);
        chk("rst_wen_ren", {bus.wen, bus.ren}, 0);
        chk("rst_bus_regs", {bus.waddr, bus.wdata, bus.wstrb}, 0);
        chk("rst_raddr", bus.raddr, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);

        // Stray handshakes while idle change nothing
        stray = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stray_cmd_ready", bus.cmd_ready, 1);
            chk("stray_rsp_valid", bus.rsp_valid, 0);
            chk("stray_strobes", {bus.wen, bus.ren}, 0);
        end
        stray = 1'b0;
        tick();

        // Basic write, responder always ready
        w_wait = -2;
        do_cmd(1'b1, 32'h20, 32'h0000_A5A5, 4'b0011, 32'h0, 1'b0, 2, 1, "wr_basic", t);
        tick();

        // Basic read, immediate GPIO-style response
        r_wait = 0;
        rd_val = 32'h0000_1234;
        do_cmd(1'b0, 32'h20, 32'h0, 4'h0, 32'h0000_1234, 1'b0, 3, 1, "rd_basic", t);
        tick();

        // Wait states
        w_wait = 2;
        do_cmd(1'b1, 32'h104, 32'hCAFE_F00D, 4'b1100, 32'h0, 1'b0, 4, 3, "wr_wait2", t);
        tick();
        r_wait = 3;
        rd_val = 32'hDEAD_BEEF;
        do_cmd(1'b0, 32'h208, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 6, 4, "rd_wait3", t);
        tick();

        // Read timeout: 16 waiting cycles, ren-low cycle, then error response
        r_wait = -1;
        rd_val = 32'hFFFF_FFFF;
        do_cmd(1'b0, 32'h30C, 32'h0, 4'h0, 32'h0, 1'b1, 18, 16, "rd_timeout", t);
        tick();

        // wready first in the last waiting cycle: handshake wins
        w_wait = 15;
        do_cmd(1'b1, 32'h40, 32'h1357_9BDF, 4'hF, 32'h0, 1'b0, 17, 16, "wr_edge", t);
        tick();

        // Write timeout
        w_wait = -1;
        do_cmd(1'b1, 32'h44, 32'h2468_ACE0, 4'h1, 32'h0, 1'b1, 17, 16, "wr_timeout", t);
        tick();

        // Response back-pressure with a pending command, then back-to-back accept
        w_wait = -2;
        r_wait = 0;
        rd_val = 32'h0000_5A5A;
        bus.rsp_ready = 1'b0;
        do_cmd(1'b0, 32'h30, 32'h0, 4'h0, 32'h0000_5A5A, 1'b0, 3, 1, "rd_hold", t);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b1;
        bus.cmd_addr  = 32'h48;
        bus.cmd_wdata = 32'h1111_2222;
        bus.cmd_wstrb = 4'hF;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_rsp_valid", bus.rsp_valid, 1);
            chk("hold_rsp_rdata", bus.rsp_rdata, 32'h0000_5A5A);
            chk("hold_cmd_ready", bus.cmd_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        do_cmd(1'b1, 32'h48, 32'h1111_2222, 4'hF, 32'h0, 1'b0, 2, 1, "wr_b2b", t);
        chk("b2b_accept_wait", t, 1);
        tick();

        // Reset during a read wait abandons the transaction
        r_wait = -1;
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = 32'h50;
        #1;
        chk("rstmid_cmd_ready", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        repeat (4) tick();
        chk("rstmid_ren_before", bus.ren, 1);
        rst = 1'b1;
        tick();
        chk("rstmid_ren_dropped", bus.ren, 0);
        chk("rstmid_cmd_ready_in_rst", bus.cmd_ready, 0);
        rst = 1'b0;
        #1;
        chk("rstmid_cmd_ready_after", bus.cmd_ready, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rstmid_no_rsp", bus.rsp_valid, 0);
        end

        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);
        chk("wen_ren_exclusive", excl_bad, 0);
        chk("strobe_payload_stable", unstable, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lbus_master.md
LBUS_MASTER -- requirements
Module: lbus_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, local bus address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter STRB_W, default DATA_W/8, byte-strobe width.
REQ-004 SHALL have parameter TIMEOUT, default 16, max wait cycles for wready/rvalid before error (≥2).
REQ-005 SHALL have ports: clk in 1, sole clock; rst in 1, reset, synchronous and active-high.
REQ-006 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_we in 1 (1=write); cmd_addr in ADDR_W; cmd_wdata in DATA_W; cmd_wstrb in STRB_W.
REQ-007 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_rdata out DATA_W; rsp_err out 1 (timeout).
REQ-008 SHALL have local bus initiator ports: waddr out ADDR_W; wdata out DATA_W; wen out 1; wstrb out STRB_W; wready in 1; raddr out ADDR_W; ren out 1; rdata in DATA_W; rvalid in 1.

Function
REQ-009 SHALL implement FSM states IDLE, WRITE, READ, READ_END, RESP.
REQ-010 SHALL assert cmd_ready only in IDLE; a command is accepted when cmd_valid && cmd_ready, capturing all cmd_* fields into registers.
REQ-011 SHALL go IDLE->WRITE on accepted write, IDLE->READ on accepted read, with bus outputs driven from the captured registers starting the next cycle.
REQ-012 WRITE: wen=1 with waddr/wdata/wstrb held stable; transfer completes in the first cycle wready=1; next cycle wen=0, state RESP, rsp_err=0, rsp_rdata=0.
REQ-013 READ: ren=1 with raddr held stable; in the first cycle rvalid=1, capture rdata into rsp_rdata, rsp_err=0, go READ_END.
REQ-014 READ_END: ren=0 for exactly one cycle (lets responder clear rvalid), then RESP.
REQ-015 Timeout counter SHALL clear on entering WRITE/READ, increment each cycle waiting; when it reaches TIMEOUT without handshake, drop wen/ren, set rsp_err=1, rsp_rdata=0, go RESP (reads via READ_END).
REQ-016 Handshake in the same cycle the counter reaches TIMEOUT SHALL win: normal completion, rsp_err=0.
REQ-017 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_valid && rsp_ready; then IDLE; rsp_ready low holds indefinitely with no new command accepted.
REQ-018 SHALL never assert wen and ren simultaneously; wen/ren SHALL be 0 in IDLE and RESP.
REQ-019 Minimum latency, zero-wait responder: write accept->rsp_valid 2 cycles; read accept->rsp_valid 3 cycles (READ, READ_END, RESP).
REQ-020 Outputs waddr/raddr/wdata/wstrb SHALL be registered; no combinational path from cmd_* to bus outputs.
REQ-021 rvalid/wready arriving while not in READ/WRITE SHALL be ignored.

Reset
REQ-022 On rst=1 at a clock edge: state IDLE, cmd_ready=0 during reset and 1 the cycle after, rsp_valid=0, rsp_err=0, rsp_rdata=0, wen=0, ren=0, waddr/raddr/wdata/wstrb=0, counter=0.
REQ-023 Reset mid-transaction SHALL abandon it with no response generated; bus strobes drop on the reset edge.

Structure
REQ-024 FSM state encoding and localparam for default TIMEOUT SHALL live in shared package lbus_pkg, reused by future local-bus blocks.
REQ-025 Single module; no sub-module required (timeout counter inline).

Verification
REQ-026 Write 0x20 data 0x0000_A5A5 strb 4'b0011, responder wready=1 constant -> wen high 1 cycle with those values, rsp_valid 2 cycles after accept, rsp_err=0.
REQ-027 Read 0x20 against GPIO-style responder returning 0x0000_1234 -> ren high until rvalid, one idle ren cycle, rsp_rdata=0x0000_1234, rsp_err=0, latency 3.
REQ-028 Read with rvalid tied 0, TIMEOUT=16 -> ren drops after 16 waiting cycles, rsp_err=1, rsp_rdata=0.
REQ-029 Write with wready first high in the exact cycle counter hits TIMEOUT -> rsp_err=0 completion.
REQ-030 rsp_ready held 0 for 10 cycles with cmd_valid=1 -> rsp_valid/rsp_rdata stable, cmd_ready=0 throughout; back-to-back accepted after release.
REQ-031 rst pulsed during READ wait -> ren=0 next cycle, no rsp_valid, cmd_ready=1 after reset deasserts.
